timer_tick_scheduler: RTL and testbench
=======================================

Name: timer_tick_scheduler

Overview:
Avalon-MM master that owns the 16-bit interval timer peripheral (status at address 0, control at address 1, readdata registered one cycle).
- Enables the timer IRQ after reset.
- Services each timeout: reads status, confirms the TO bit, clears it.
- Distributes the resulting system tick to NUM_CH software-style alarm channels, each one-shot or periodic.
- Replaces per-requester hardware timers with one shared timer plus tick-counted deadlines.

Parameters:
NUM_CH, 4, number of alarm channels
TICK_W, 16, width of per-channel tick count

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avm_address  out  3  timer slave address
avm_chipselect  out  1  timer slave select
avm_write_n  out  1  active-low write strobe
avm_writedata  out  16  write data to timer
avm_readdata  in  16  timer readdata, registered inside the timer (valid the cycle after the address is presented)
timer_irq  in  1  timer interrupt, level
ch_start  in  NUM_CH  per-channel start pulse
ch_stop  in  NUM_CH  per-channel cancel pulse
ch_periodic  in  NUM_CH  mode, sampled at start (1 = auto-reload)
ch_ticks  in  NUM_CH*TICK_W  per-channel period in ticks, channel i at bits [i*TICK_W +: TICK_W], sampled at start
ch_active  out  NUM_CH  channel armed
ch_expire  out  NUM_CH  one-cycle expiry pulse
tick_count  out  32  confirmed ticks since reset, wraps at 2^32
spurious_count  out  8  IRQs with TO=0, saturates at 255

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Reset values:
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - ch_active=0, ch_expire=0, tick_count=0, spurious_count=0.
  - All channel counters and latched periods 0.
  - FSM=INIT.
- Bus idle (IDLE and CHK): chipselect=0, write_n=1, address=0, writedata=0.
- FSM, one cycle per state unless stated:
  - INIT: chipselect=1, write_n=0, address=1, writedata=16'h0001 (ITO enable) -> IDLE.
  - IDLE: stay while timer_irq=0; if timer_irq=1 -> RD.
  - RD: chipselect=1, write_n=1, address=0 (status read) -> CHK.
  - CHK: sample avm_readdata[0]. If 1 -> CLR; if 0 -> increment spurious_count (saturating) -> IDLE.
  - CLR: chipselect=1, write_n=0, address=0, writedata=0 (clear TO) -> TICK.
  - TICK: tick_count += 1; apply tick to channels -> IDLE. timer_irq is already low here; IDLE never re-reads the same event.
- Latency: IRQ rising edge seen in IDLE at cycle n -> clear write in cycle n+3 -> tick applied at the end of cycle n+4 -> ch_expire high in cycle n+5.
- Channel i start (ch_start[i]=1 in any state):
  - Latch period P=ch_ticks[i], or 1 if ch_ticks[i]=0.
  - Latch the ch_periodic[i] bit.
  - Load counter with P; ch_active[i]=1 next cycle.
  - Restarting an active channel reloads it.
- Tick (TICK state), for each active channel with no start/stop this cycle:
  - Counter > 1: decrement.
  - Counter == 1: ch_expire[i]=1 next cycle. If periodic, reload P; else clear ch_active[i].
- Simultaneous events, same cycle, same channel:
  - start+stop: start wins.
  - start+TICK: start wins (load, no decrement, no expire).
  - stop+TICK at counter==1: stop wins, no expire.
  - stop on an inactive channel: no effect.
- Channels are independent; multiple ch_expire bits may pulse together.
- ch_expire is a registered pulse, exactly one cycle wide.
- Reset asserted mid-sequence (any state): immediate return to reset values. Release re-runs INIT, so the IRQ enable is rewritten even if the timer was not reset.
- avm_readdata is ignored outside CHK.

Test Plan:
- Reset release -> cycle 1: address=1, chipselect=1, write_n=0, writedata=16'h0001; then bus idle in IDLE.
- Timer model raises irq with status readdata=16'h0003 -> read of address 0, then write address 0 data 0 three cycles after the irq edge; tick_count 0->1; irq drops before IDLE.
- irq raised with readdata[0]=0 -> no write to address 0; spurious_count=1; tick_count unchanged. Repeat 300 times -> spurious_count holds 255.
- ch0 start, ch_ticks=3, one-shot; ch1 start, ch_ticks=2, periodic; issue 6 ticks:
  - ch0: single ch_expire[0] after tick 3, then ch_active[0]=0.
  - ch1: ch_expire[1] after ticks 2, 4, 6; ch_active[1] stays 1.
- Collisions on ch2 (ch_ticks=1): ch_stop[2] in the TICK cycle -> no expire. ch_start[2] in the TICK cycle -> counter reloaded, no expire on that tick. ch_ticks=0 -> expires after 1 tick.
- Assert reset_n=0 during CLR with ch0 active -> all outputs at reset values immediately; after release INIT is repeated and ch_active=0.

Source files
------------

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master servicing a 16-bit interval timer and fanning its timeout
// out as a shared system tick to NUM_CH one-shot/periodic alarm channels.
module timer_tick_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TICK_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [2:0]               avm_address,
  output logic                     avm_chipselect,
  output logic                     avm_write_n,
  output logic [15:0]              avm_writedata,
  input  logic [15:0]              avm_readdata,
  input  logic                     timer_irq,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_stop,
  input  logic [NUM_CH-1:0]        ch_periodic,
  input  logic [NUM_CH*TICK_W-1:0] ch_ticks,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [NUM_CH-1:0]        ch_expire,
  output logic [31:0]              tick_count,
  output logic [7:0]               spurious_count
);

  localparam int unsigned AW       = 3;
  localparam int unsigned DW       = 16;
  localparam int unsigned SPUR_W   = 8;
  localparam int unsigned CNT_W    = 32;
  localparam logic [AW-1:0] A_STAT = AW'(0);
  localparam logic [AW-1:0] A_CTRL = AW'(1);
  localparam logic [DW-1:0] ITO_EN = DW'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_CHK,
    S_CLR,
    S_TICK
  } state_t;

  state_t state;
  // Set only out of reset so the IRQ-enable write lands in the first cycle after release.
  logic   boot;
  logic   tick_c;
  logic   unused_rd;

  logic [TICK_W-1:0] cnt_q   [NUM_CH];
  logic [TICK_W-1:0] per_q   [NUM_CH];
  logic [TICK_W-1:0] load_c  [NUM_CH];
  logic [NUM_CH-1:0] periodic_q;

  assign tick_c    = (state == S_TICK);
  assign unused_rd = ^avm_readdata[DW-1:1];

  // Bus sequencer: bus outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_INIT;
      boot           <= 1'b1;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      tick_count     <= '0;
      spurious_count <= '0;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      case (state)
        S_INIT: begin
          if (boot) begin
            boot           <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= A_CTRL;
            avm_writedata  <= ITO_EN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (timer_irq) begin
            state          <= S_RD;
            avm_chipselect <= 1'b1;
            avm_address    <= A_STAT;
          end
        end
        S_RD: state <= S_CHK;
        S_CHK: begin
          if (avm_readdata[0]) begin
            state          <= S_CLR;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= A_STAT;
          end else begin
            if (spurious_count != '1)
              spurious_count <= spurious_count + SPUR_W'(1);
            state <= S_IDLE;
          end
        end
        S_CLR: state <= S_TICK;
        S_TICK: begin
          tick_count <= tick_count + CNT_W'(1);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A zero period is promoted to one tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load_c[i] = ch_ticks[i*TICK_W +: TICK_W];
      if (load_c[i] == '0)
        load_c[i] = TICK_W'(1);
    end
  end

  // Alarm channels: start beats stop, and both beat the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_active  <= '0;
      ch_expire  <= '0;
      periodic_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        per_q[i] <= '0;
      end
    end else begin
      ch_expire <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_start[i]) begin
          per_q[i]      <= load_c[i];
          cnt_q[i]      <= load_c[i];
          periodic_q[i] <= ch_periodic[i];
          ch_active[i]  <= 1'b1;
        end else if (ch_stop[i]) begin
          ch_active[i] <= 1'b0;
        end else if (tick_c && ch_active[i]) begin
          if (cnt_q[i] > TICK_W'(1)) begin
            cnt_q[i] <= cnt_q[i] - TICK_W'(1);
          end else begin
            ch_expire[i] <= 1'b1;
            if (periodic_q[i])
              cnt_q[i] <= per_q[i];
            else
              ch_active[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler with a small timer model, a bus
// transaction scoreboard and a reference model of the alarm channels.
module tb_timer_tick_scheduler;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned TICK_W = 16;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [2:0]               avm_address;
  logic                     avm_chipselect;
  logic                     avm_write_n;
  logic [15:0]              avm_writedata;
  logic [15:0]              avm_readdata = 16'hFFFF;
  logic                     timer_irq;
  logic [NUM_CH-1:0]        ch_start;
  logic [NUM_CH-1:0]        ch_stop;
  logic [NUM_CH-1:0]        ch_periodic;
  logic [NUM_CH*TICK_W-1:0] ch_ticks;
  logic [NUM_CH-1:0]        ch_active;
  logic [NUM_CH-1:0]        ch_expire;
  logic [31:0]              tick_count;
  logic [7:0]               spurious_count;

  logic [15:0] rd_status;
  int n_cmp = 0;
  int n_bad = 0;

  // Expected bus transactions {is_write, address, writedata}.
  logic [19:0] exp_bus[$];

  // Reference model of channels and counters.
  int          m_cnt [NUM_CH];
  int          m_per [NUM_CH];
  bit          m_act [NUM_CH];
  bit          m_pp  [NUM_CH];
  int          m_ticks;
  int          m_spur;

  timer_tick_scheduler #(.NUM_CH(NUM_CH), .TICK_W(TICK_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .timer_irq      (timer_irq),
    .ch_start       (ch_start),
    .ch_stop        (ch_stop),
    .ch_periodic    (ch_periodic),
    .ch_ticks       (ch_ticks),
    .ch_active      (ch_active),
    .ch_expire      (ch_expire),
    .tick_count     (tick_count),
    .spurious_count (spurious_count)
  );

  always #5 clk = ~clk;

  // Timer readdata is registered; outside a status read it returns junk.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n && avm_address == 3'd0)
      avm_readdata <= rd_status;
    else
      avm_readdata <= 16'hFFFF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor pops the scoreboard for every selected cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && avm_chipselect === 1'b1) begin
      if (exp_bus.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL bus_unexpected: observed %0h expected none",
               {~avm_write_n, avm_address, avm_writedata});
      end else begin
        check("bus_txn", 32'({~avm_write_n, avm_address, avm_writedata}), 32'(exp_bus.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_per[i] = 0; m_act[i] = 0; m_pp[i] = 0;
    end
    m_ticks = 0;
    m_spur  = 0;
  endtask

  task automatic model_load(input int i);
    int t;
    t = int'(ch_ticks[i*TICK_W +: TICK_W]);
    m_per[i] = (t == 0) ? 1 : t;
    m_cnt[i] = m_per[i];
    m_pp[i]  = ch_periodic[i];
    m_act[i] = 1'b1;
  endtask

  function automatic logic [NUM_CH-1:0] model_active();
    logic [NUM_CH-1:0] a;
    for (int i = 0; i < NUM_CH; i++) a[i] = m_act[i];
    return a;
  endfunction

  // Called just after a negedge; start pulse lasts one cycle.
  task automatic start_ch(input int i, input int ticks, input bit per);
    ch_ticks[i*TICK_W +: TICK_W] = 16'(ticks);
    ch_periodic[i] = per;
    ch_start[i]    = 1'b1;
    model_load(i);
    @(negedge clk);
    ch_start = '0;
    check("start_active", 32'(ch_active), 32'(model_active()));
  endtask

  // One full timeout service; st/sp are driven during the TICK cycle.
  task automatic do_tick(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp);
    logic [NUM_CH-1:0] exp_x;
    exp_bus.push_back({1'b0, 3'd0, 16'h0000});
    exp_bus.push_back({1'b1, 3'd0, 16'h0000});
    rd_status = 16'h0003;
    timer_irq = 1'b1;
    repeat (3) @(negedge clk);
    check("clr_cycle", 32'({avm_chipselect, avm_write_n, avm_address}), 32'({1'b1, 1'b0, 3'd0}));
    timer_irq = 1'b0;
    @(negedge clk);
    ch_start = st;
    ch_stop  = sp;
    exp_x = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (st[i]) model_load(i);
      else if (sp[i]) m_act[i] = 1'b0;
      else if (m_act[i]) begin
        if (m_cnt[i] > 1) m_cnt[i]--;
        else begin
          exp_x[i] = 1'b1;
          if (m_pp[i]) m_cnt[i] = m_per[i];
          else m_act[i] = 1'b0;
        end
      end
    end
    m_ticks++;
    @(negedge clk);
    ch_start = '0;
    ch_stop  = '0;
    check("expire", 32'(ch_expire), 32'(exp_x));
    check("tick_count", tick_count, 32'(m_ticks));
    check("active", 32'(ch_active), 32'(model_active()));
    @(negedge clk);
    check("expire_pulse", 32'(ch_expire), 32'h0);
  endtask

  task automatic do_spurious();
    exp_bus.push_back({1'b0, 3'd0, 16'h0000});
    rd_status = 16'h0000;
    timer_irq = 1'b1;
    @(negedge clk);
    timer_irq = 1'b0;
    repeat (3) @(negedge clk);
    if (m_spur < 255) m_spur++;
  endtask

  initial begin
    reset_n     = 1'b0;
    timer_irq   = 1'b0;
    ch_start    = '0;
    ch_stop     = '0;
    ch_periodic = '0;
    ch_ticks    = '0;
    rd_status   = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(avm_chipselect), 32'h0);
    check("rst_wn", 32'(avm_write_n), 32'h1);
    check("rst_addr", 32'(avm_address), 32'h0);
    check("rst_wd", 32'(avm_writedata), 32'h0);
    check("rst_active", 32'(ch_active), 32'h0);
    check("rst_expire", 32'(ch_expire), 32'h0);
    check("rst_ticks", tick_count, 32'h0);
    check("rst_spur", 32'(spurious_count), 32'h0);

    exp_bus.push_back({1'b1, 3'd1, 16'h0001});
    reset_n = 1'b1;
    @(negedge clk);
    check("init_write", 32'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
          32'({1'b1, 1'b0, 3'd1, 16'h0001}));
    @(negedge clk);
    check("idle_bus", 32'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
          32'({1'b0, 1'b1, 3'd0, 16'h0000}));

    do_tick('0, '0);
    check("first_tick", tick_count, 32'd1);

    do_spurious();
    check("spur_one", 32'(spurious_count), 32'd1);
    check("spur_ticks", tick_count, 32'd1);
    for (int k = 0; k < 299; k++) do_spurious();
    check("spur_sat", 32'(spurious_count), 32'd255);
    check("spur_model", 32'(spurious_count), 32'(m_spur));

    start_ch(0, 3, 1'b0);
    start_ch(1, 2, 1'b1);
    for (int k = 0; k < 6; k++) do_tick('0, '0);
    check("ch_after6", 32'(ch_active), 32'b0010);

    start_ch(2, 1, 1'b0);
    do_tick('0, 4'b0100);
    check("stop_tick", 32'(ch_active[2]), 32'h0);
    start_ch(2, 1, 1'b0);
    do_tick(4'b0100, '0);
    check("start_tick", 32'(ch_active[2]), 32'h1);
    do_tick('0, '0);
    start_ch(2, 0, 1'b0);
    do_tick('0, 4'b1000);

    start_ch(0, 5, 1'b0);
    exp_bus.push_back({1'b0, 3'd0, 16'h0000});
    exp_bus.push_back({1'b1, 3'd0, 16'h0000});
    rd_status = 16'h0003;
    timer_irq = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_bus", 32'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
          32'({1'b0, 1'b1, 3'd0, 16'h0000}));
    check("mid_rst_active", 32'(ch_active), 32'h0);
    check("mid_rst_ticks", tick_count, 32'h0);
    check("mid_rst_spur", 32'(spurious_count), 32'h0);
    timer_irq = 1'b0;
    model_reset();
    @(negedge clk);
    exp_bus.push_back({1'b1, 3'd1, 16'h0001});
    reset_n = 1'b1;
    @(negedge clk);
    check("reinit_write", 32'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
          32'({1'b1, 1'b0, 3'd1, 16'h0001}));
    check("reinit_active", 32'(ch_active), 32'h0);
    repeat (2) @(negedge clk);
    check("bus_drained", 32'(exp_bus.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
